// File: rtl/mpc_dense_pkg.sv
// Shared definitions for the dense-constraint stages of the implicit MPC:
// widths, fixed-point limits, FSM states and the saturating subtract.
package mpc_dense_pkg;

   localparam int DW      = 20;
   localparam int AW      = 3;
   localparam int NROWS   = 8;
   localparam int CW      = 4;
   localparam int FX_FRAC = 16;

   localparam logic [DW-1:0] FX_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] FX_MIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // a - b computed one bit wider; clamps instead of wrapping
   function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] d;
      d = {a[DW-1], a} - {b[DW-1], b};
      if (d[DW] != d[DW-1]) begin
         return d[DW] ? FX_MIN : FX_MAX;
      end
      return d[DW-1:0];
   endfunction

endpackage

// File: rtl/mpc_dense_constraint_vsub_residual.sv
// Residual stage: streams r[i] = sat(e[i] - gx[i]) for every constraint row
// and counts the rows whose residual is negative.
module mpc_dense_constraint_vsub_residual
   import mpc_dense_pkg::*;
(
   input  logic          ap_clk,
   input  logic          ap_rst_n,
   input  logic          ap_start,
   output logic          ap_done,
   output logic          ap_idle,
   output logic          ap_ready,
   output logic [AW-1:0] e_address0,
   output logic          e_ce0,
   input  logic [DW-1:0] e_q0,
   input  logic [DW-1:0] gx_dout,
   input  logic          gx_empty_n,
   output logic          gx_read,
   output logic [DW-1:0] res_din,
   input  logic          res_full_n,
   output logic          res_write,
   output logic [CW-1:0] viol_count
);

   state_t        state;
   logic [AW-1:0] row;
   logic          s1_valid;
   logic [DW-1:0] gx_reg;
   logic          adv;
   logic          issue;
   logic          last_row;
   logic [DW-1:0] resid;

   // Stall decision comes first; a row is issued only when the pipe can move
   always_comb begin
      adv        = !s1_valid || res_full_n;
      issue      = (state == ST_RUN) && gx_empty_n && adv;
      last_row   = (row == AW'(NROWS - 1));
      resid      = sat_sub(e_q0, gx_reg);
      e_ce0      = issue;
      gx_read    = issue;
      e_address0 = row;
      res_write  = s1_valid && res_full_n;
      res_din    = s1_valid ? resid : '0;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state      <= ST_IDLE;
         row        <= '0;
         s1_valid   <= 1'b0;
         gx_reg     <= '0;
         viol_count <= '0;
         ap_done    <= 1'b0;
         ap_ready   <= 1'b0;
         ap_idle    <= 1'b1;
      end else begin
         ap_done  <= 1'b0;
         ap_ready <= 1'b0;

         if (adv) begin
            s1_valid <= issue;
         end
         if (issue) begin
            gx_reg <= gx_dout;
         end
         if (res_write && resid[DW-1] && (viol_count != {CW{1'b1}})) begin
            viol_count <= viol_count + CW'(1);
         end

         // Done is flagged while the final residual leaves stage 1
         case (state)
            ST_IDLE: begin
               if (ap_start) begin
                  state      <= ST_RUN;
                  row        <= '0;
                  viol_count <= '0;
                  ap_idle    <= 1'b0;
               end
            end
            ST_RUN: begin
               if (issue) begin
                  if (last_row) begin
                     state <= ST_DRAIN;
                  end else begin
                     row <= row + AW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (!s1_valid || res_write) begin
                  state    <= ST_DONE;
                  ap_done  <= 1'b1;
                  ap_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               ap_idle <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpc_dense_constraint_vsub_residual.sv
// Directed bench for the residual stage with a modelled bound ROM
// (even rows 0xA0000, odd rows 0x6487F) and a modelled gx FIFO.
module tb_mpc_dense_constraint_vsub_residual;

   localparam logic [19:0] E_EVEN = 20'hA0000;
   localparam logic [19:0] E_ODD  = 20'h6487F;

   logic        ap_clk;
   logic        ap_rst_n;
   logic        ap_start;
   logic        ap_done;
   logic        ap_idle;
   logic        ap_ready;
   logic [2:0]  e_address0;
   logic        e_ce0;
   logic [19:0] e_q0;
   logic [19:0] gx_dout;
   logic        gx_empty_n;
   logic        gx_read;
   logic [19:0] res_din;
   logic        res_full_n;
   logic        res_write;
   logic [3:0]  viol_count;

   logic [19:0] gx_mem [0:31];
   int          gx_ptr;
   int          gx_cnt;
   logic        gx_flush;
   logic        gx_block;

   int          vec_n;
   int          miscmp_n;

   logic [19:0] wr_val [0:31];
   int          wr_cyc [0:31];
   int          wr_n;
   int          done_cyc [0:1];
   int          done_n;
   int          idle_n;
   int          stall_bad;
   int          ready_bad;

   mpc_dense_constraint_vsub_residual dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .ap_start   (ap_start),
      .ap_done    (ap_done),
      .ap_idle    (ap_idle),
      .ap_ready   (ap_ready),
      .e_address0 (e_address0),
      .e_ce0      (e_ce0),
      .e_q0       (e_q0),
      .gx_dout    (gx_dout),
      .gx_empty_n (gx_empty_n),
      .gx_read    (gx_read),
      .res_din    (res_din),
      .res_full_n (res_full_n),
      .res_write  (res_write),
      .viol_count (viol_count)
   );

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   always @(posedge ap_clk) begin
      if (e_ce0) begin
         e_q0 <= e_address0[0] ? E_ODD : E_EVEN;
      end
   end

   always @(posedge ap_clk) begin
      if (gx_flush) begin
         gx_ptr <= 0;
      end else if (gx_read) begin
         gx_ptr <= gx_ptr + 1;
      end
   end

   assign gx_empty_n = (gx_ptr < gx_cnt) && !gx_block;
   assign gx_dout    = gx_mem[gx_ptr[4:0]];

   function automatic logic [19:0] rom_val(input int i);
      return (i % 2 == 1) ? E_ODD : E_EVEN;
   endfunction

   task automatic load_zero_gx(input int cnt);
      for (int i = 0; i < 32; i++) gx_mem[i] = 20'h0;
      gx_cnt   = cnt;
      gx_flush = 1'b1;
      @(posedge ap_clk); #1;
      gx_flush = 1'b0;
   endtask

   // Start a pass and record outputs cycle by cycle; cycle 1 is the first RUN cycle
   task automatic run_pass(input int full_lo, input int full_hi, input int blk_lo,
                           input int blk_hi, input bit hold, input int want_done,
                           input int rst_cyc);
      wr_n = 0; done_n = 0; idle_n = 0; stall_bad = 0; ready_bad = 0;
      ap_start = 1'b1;
      @(posedge ap_clk); #1;
      if (!hold) ap_start = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         if (n == rst_cyc) begin
            ap_rst_n = 1'b0;
            ap_start = 1'b0;
            return;
         end
         res_full_n = !(n >= full_lo && n <= full_hi);
         gx_block   = (n >= blk_lo && n <= blk_hi);
         @(negedge ap_clk);
         if (res_write && wr_n < 32) begin
            wr_val[wr_n] = res_din;
            wr_cyc[wr_n] = n;
            wr_n++;
         end
         if (!res_full_n && (e_ce0 || gx_read || res_write)) stall_bad++;
         if (ap_ready !== ap_done) ready_bad++;
         if (ap_idle) idle_n++;
         if (ap_done && done_n < 2) begin
            done_cyc[done_n] = n;
            done_n++;
         end
         @(posedge ap_clk); #1;
         if (done_n == want_done) break;
      end
      res_full_n = 1'b1;
      gx_block   = 1'b0;
      ap_start   = 1'b0;
   endtask

   task automatic test_reset;
      ap_rst_n = 1'b0;
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      vec_n++;
      if ({ap_idle, ap_done, ap_ready} !== 3'b100) begin
         $display("[TB] FAIL reset_ctrl idle/done/ready got %b want 100", {ap_idle, ap_done, ap_ready});
         miscmp_n++;
      end
      vec_n++;
      if ({e_ce0, gx_read, res_write} !== 3'b000) begin
         $display("[TB] FAIL reset_strobes ce0/read/write got %b want 000", {e_ce0, gx_read, res_write});
         miscmp_n++;
      end
      vec_n++;
      if (res_din !== 20'h0 || viol_count !== 4'h0 || e_address0 !== 3'h0) begin
         $display("[TB] FAIL reset_data res_din=%h viol=%0d addr=%0d want 0/0/0", res_din, viol_count, e_address0);
         miscmp_n++;
      end
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
   endtask

   task automatic test_basic;
      load_zero_gx(8);
      run_pass(99, 99, 99, 99, 1'b0, 1, 0);
      vec_n++;
      if (wr_n !== 8) begin
         $display("[TB] FAIL basic_count got %0d want 8", wr_n);
         miscmp_n++;
      end
      for (int i = 0; i < 8; i++) begin
         vec_n++;
         if (wr_val[i] !== rom_val(i)) begin
            $display("[TB] FAIL basic_row%0d got %h want %h", i, wr_val[i], rom_val(i));
            miscmp_n++;
         end
      end
      vec_n++;
      if (wr_cyc[0] !== 2) begin
         $display("[TB] FAIL basic_latency first write cycle %0d want 2", wr_cyc[0]);
         miscmp_n++;
      end
      vec_n++;
      if (done_n !== 1 || done_cyc[0] !== 10) begin
         $display("[TB] FAIL basic_done count %0d cycle %0d want 1 at 10", done_n, done_cyc[0]);
         miscmp_n++;
      end
      vec_n++;
      if (viol_count !== 4'd4) begin
         $display("[TB] FAIL basic_viol got %0d want 4", viol_count);
         miscmp_n++;
      end
      vec_n++;
      if (ready_bad !== 0 || idle_n !== 0) begin
         $display("[TB] FAIL basic_handshake ready_bad=%0d idle_cycles=%0d want 0/0", ready_bad, idle_n);
         miscmp_n++;
      end
      repeat (2) @(posedge ap_clk); #1;
      vec_n++;
      if (ap_idle !== 1'b1) begin
         $display("[TB] FAIL basic_idle_after got %b want 1", ap_idle);
         miscmp_n++;
      end
   endtask

   task automatic test_saturation;
      load_zero_gx(8);
      gx_mem[0] = 20'h7FFFF;
      gx_mem[1] = 20'h80000;
      run_pass(99, 99, 99, 99, 1'b0, 1, 0);
      vec_n++;
      if (wr_val[0] !== 20'h80000) begin
         $display("[TB] FAIL sat_neg got %h want 80000", wr_val[0]);
         miscmp_n++;
      end
      vec_n++;
      if (wr_val[1] !== 20'h7FFFF) begin
         $display("[TB] FAIL sat_pos got %h want 7ffff", wr_val[1]);
         miscmp_n++;
      end
      vec_n++;
      if (wr_val[2] !== E_EVEN || wr_n !== 8) begin
         $display("[TB] FAIL sat_rest row2 %h count %0d want a0000/8", wr_val[2], wr_n);
         miscmp_n++;
      end
      vec_n++;
      if (viol_count !== 4'd4) begin
         $display("[TB] FAIL sat_viol got %0d want 4", viol_count);
         miscmp_n++;
      end
      repeat (2) @(posedge ap_clk); #1;
   endtask

   task automatic test_output_stall;
      load_zero_gx(8);
      run_pass(3, 6, 99, 99, 1'b0, 1, 0);
      vec_n++;
      if (wr_n !== 8) begin
         $display("[TB] FAIL stall_count got %0d want 8", wr_n);
         miscmp_n++;
      end
      for (int i = 0; i < 8; i++) begin
         vec_n++;
         if (wr_val[i] !== rom_val(i)) begin
            $display("[TB] FAIL stall_row%0d got %h want %h", i, wr_val[i], rom_val(i));
            miscmp_n++;
         end
      end
      vec_n++;
      if (stall_bad !== 0) begin
         $display("[TB] FAIL stall_frozen active strobes in %0d stalled cycles want 0", stall_bad);
         miscmp_n++;
      end
      vec_n++;
      if (wr_cyc[1] !== 7 || done_cyc[0] !== 14) begin
         $display("[TB] FAIL stall_timing row1 at %0d done at %0d want 7/14", wr_cyc[1], done_cyc[0]);
         miscmp_n++;
      end
      repeat (2) @(posedge ap_clk); #1;
   endtask

   task automatic test_input_bubble;
      load_zero_gx(8);
      gx_mem[3] = 20'h00010;
      run_pass(99, 99, 4, 6, 1'b0, 1, 0);
      vec_n++;
      if (wr_n !== 8 || wr_val[3] !== 20'h6486F) begin
         $display("[TB] FAIL bubble_row3 count %0d r3 %h want 8/6486f", wr_n, wr_val[3]);
         miscmp_n++;
      end
      vec_n++;
      if (wr_cyc[2] !== 4 || wr_cyc[3] !== 8) begin
         $display("[TB] FAIL bubble_gap rows2/3 at %0d/%0d want 4/8", wr_cyc[2], wr_cyc[3]);
         miscmp_n++;
      end
      vec_n++;
      if (wr_val[4] !== E_EVEN || wr_val[7] !== E_ODD) begin
         $display("[TB] FAIL bubble_tail r4 %h r7 %h want a0000/6487f", wr_val[4], wr_val[7]);
         miscmp_n++;
      end
      vec_n++;
      if (done_cyc[0] !== 13) begin
         $display("[TB] FAIL bubble_done got %0d want 13", done_cyc[0]);
         miscmp_n++;
      end
      repeat (2) @(posedge ap_clk); #1;
   endtask

   task automatic test_mid_reset;
      load_zero_gx(8);
      run_pass(99, 99, 99, 99, 1'b0, 1, 7);
      vec_n++;
      if (wr_n !== 5) begin
         $display("[TB] FAIL midrst_partial writes %0d want 5", wr_n);
         miscmp_n++;
      end
      @(negedge ap_clk);
      vec_n++;
      if ({ap_idle, ap_done, e_ce0, gx_read, res_write} !== 5'b10000 || viol_count !== 4'd0 || res_din !== 20'h0) begin
         $display("[TB] FAIL midrst_state ctrl %b viol %0d res %h want 10000/0/0",
                  {ap_idle, ap_done, e_ce0, gx_read, res_write}, viol_count, res_din);
         miscmp_n++;
      end
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      load_zero_gx(8);
      run_pass(99, 99, 99, 99, 1'b0, 1, 0);
      vec_n++;
      if (wr_n !== 8 || wr_val[0] !== E_EVEN || wr_val[7] !== E_ODD) begin
         $display("[TB] FAIL midrst_newpass count %0d r0 %h r7 %h want 8/a0000/6487f", wr_n, wr_val[0], wr_val[7]);
         miscmp_n++;
      end
      vec_n++;
      if (viol_count !== 4'd4 || done_cyc[0] !== 10) begin
         $display("[TB] FAIL midrst_viol viol %0d done %0d want 4/10", viol_count, done_cyc[0]);
         miscmp_n++;
      end
      repeat (2) @(posedge ap_clk); #1;
   endtask

   task automatic test_back_to_back;
      load_zero_gx(16);
      run_pass(99, 99, 99, 99, 1'b1, 2, 0);
      vec_n++;
      if (done_n !== 2 || done_cyc[0] !== 10 || done_cyc[1] !== 21) begin
         $display("[TB] FAIL b2b_done count %0d at %0d/%0d want 2 at 10/21", done_n, done_cyc[0], done_cyc[1]);
         miscmp_n++;
      end
      vec_n++;
      if (idle_n !== 1) begin
         $display("[TB] FAIL b2b_idle idle cycles %0d want 1", idle_n);
         miscmp_n++;
      end
      vec_n++;
      if (wr_n !== 16 || wr_val[8] !== E_EVEN || wr_val[15] !== E_ODD) begin
         $display("[TB] FAIL b2b_writes count %0d r8 %h r15 %h want 16/a0000/6487f", wr_n, wr_val[8], wr_val[15]);
         miscmp_n++;
      end
      vec_n++;
      if (viol_count !== 4'd4) begin
         $display("[TB] FAIL b2b_viol got %0d want 4", viol_count);
         miscmp_n++;
      end
      repeat (3) @(posedge ap_clk); #1;
   endtask

   initial begin
      vec_n      = 0;
      miscmp_n   = 0;
      ap_rst_n   = 1'b0;
      ap_start   = 1'b0;
      res_full_n = 1'b1;
      gx_block   = 1'b0;
      gx_flush   = 1'b1;
      gx_cnt     = 0;
      for (int i = 0; i < 32; i++) gx_mem[i] = 20'h0;
      @(posedge ap_clk); #1;
      gx_flush = 1'b0;

      test_reset();
      test_basic();
      test_saturation();
      test_output_stall();
      test_input_bubble();
      test_mid_reset();
      test_back_to_back();

      $display("== %0d vectors applied, %0d miscompares ==", vec_n, miscmp_n);
      $finish;
   end

endmodule
